lane_banked_memory: RTL
=======================

// Module: lane_banked_memory
// PURPOSE
//  Parametrised dual-port word memory built from independent byte lanes, with per-lane write
//  enables, a reset-time clear engine, configurable read latency and write-collision detection.
//  Shared instruction/data store between the fetch port (port 1) and the load/store port (port 2).
//  Successor of the fixed 32-bit, four-lane, file-initialised memory: generalised width, depth and latency.
// PARAMETERS
//  WORD_WIDTH     32    data word width; must be a multiple of LANE_WIDTH
//  LANE_WIDTH     8     bits per lane; LANES = WORD_WIDTH/LANE_WIDTH (power of two)
//  DEPTH_WORDS    1024  words per lane (power of two); IDX_W = log2(DEPTH_WORDS)
//  READ_LATENCY   1     1 or 2 cycles from accepted request to rvalid; other values are illegal
//  CLEAR_ON_RESET 1     1: zero all words after reset; 0: enter RUN directly, contents undefined
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           asynchronous reset, active high
//  ready      out  1           1 = requests accepted (RUN state)
//  req1/req2  in   1           request on port 1/2
//  we1/we2    in   LANES       per-lane write enable; all zero = pure read
//  addr1/2    in   WORD_WIDTH  byte address; word index = addr[ADDR_LSB +: IDX_W], ADDR_LSB = log2(LANES)
//  wdata1/2   in   WORD_WIDTH  write data; lane k = bits [k*LANE_WIDTH +: LANE_WIDTH]
//  rdata1/2   out  WORD_WIDTH  read data; holds its last value between rvalid pulses
//  rvalid1/2  out  1           single-cycle pulse: rdata carries the data for one request
//  collision  out  1           single-cycle pulse: both ports wrote the same lane of the same word
//  err1/err2  out  1           parity error flag, present only with MEM_PARITY_EN
// BEHAVIOUR
//  - Reset (asynchronous): ready=0, rvalid1/2=0, rdata1/2=0, collision=0, err1/2=0, pipeline flushed.
//    State goes to CLEAR if CLEAR_ON_RESET=1, else RUN.
//  - FSM CLEAR: counter runs 0..DEPTH_WORDS-1 and writes one all-zero word (all lanes) per cycle.
//    Requests are ignored: no write, no rvalid. Last word written -> RUN next cycle; ready=1 in RUN.
//    Time from reset release to ready=1 is exactly DEPTH_WORDS cycles.
//  - FSM RUN: a request is accepted when reqN & ready. No backpressure: one request per port per cycle.
//  - Address bits below ADDR_LSB are ignored. Bits above ADDR_LSB+IDX_W are ignored, so the index wraps modulo DEPTH_WORDS.
//  - Every accepted request reads the whole word. rvalidN pulses READ_LATENCY cycles after the request.
//    For READ_LATENCY=2 the extra cycle is an output register stage.
//  - Read-first ordering: the read returns pre-write contents, including a write in the same cycle
//    from the same port or from the other port to the same index.
//  - Write: lane k of word idx <= wdataN lane k when weN[k] is set; other lanes are unchanged.
//  - Same index, same lane, both ports writing: port 1 data wins; collision=1 in the following cycle.
//    Disjoint lanes on the same index: both writes apply and collision stays 0.
//  - Back-to-back requests give back-to-back rvalid pulses in issue order.
//  - rst asserted during RUN or CLEAR: in-flight reads are dropped and no rvalid is issued for them.
//    Memory contents are not guaranteed and are re-cleared if CLEAR_ON_RESET=1.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//    - Each lane stores one extra bit: the even parity of that lane, recomputed on every lane write.
//    - CLEAR writes parity 0.
//    - On read, errN=1 with rvalidN when any lane's stored parity differs from the recomputed parity;
//      errN=0 whenever rvalidN=0.
//  MEM_PARITY_EN undefined: no parity storage and no err1/err2 ports. All other behaviour is identical.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=1024: release rst at cycle 0 -> ready=0 through cycle 1023, ready=1 at 1024.
//    A subsequent read of any index returns 0.
//  2 Port 2 writes 0xDEADBEEF with we=4'b1111 at addr 0x10, then reads addr 0x13.
//    -> rdata2=0xDEADBEEF, rvalid2 READ_LATENCY cycles after the read request. Repeat with READ_LATENCY=1 and 2.
//  3 Word 0x10 = 0xDEADBEEF; port 2 writes 0x000000AA with we=4'b0001 while port 1 reads 0x10 in the same cycle.
//    -> rdata1=0xDEADBEEF. The next read returns 0xDEADBEAA.
//  4 Both ports write index 5 in the same cycle: port 1 0x11111111 we=4'b0011, port 2 0x22222222 we=4'b0110.
//    -> collision pulses once, next cycle. Word 5 reads 0x00221111 (starting from cleared memory).
//  5 Assert rst for 1 cycle with 2 reads in flight (READ_LATENCY=2).
//    -> no rvalid follows; ready drops and CLEAR reruns.
//  6 MEM_PARITY_EN: flip 1 stored data bit of word 7 lane 2 hierarchically, then read word 7.
//    -> err1=1 with rvalid1; a read of word 8 -> err1=0.

Source files
------------

// File: rtl/lane_banked_memory_if.sv
// Request/response bundle for both ports of lane_banked_memory.
// Optional err1/err2 exist only when MEM_PARITY_EN is defined.
interface lane_banked_memory_if #(
    parameter int WORD_WIDTH = 32,
    parameter int LANE_WIDTH = 8
);
    localparam int LANES = WORD_WIDTH / LANE_WIDTH;

    logic                  req1, req2;
    logic [LANES-1:0]      we1, we2;
    logic [WORD_WIDTH-1:0] addr1, addr2;
    logic [WORD_WIDTH-1:0] wdata1, wdata2;
    logic [WORD_WIDTH-1:0] rdata1, rdata2;
    logic                  rvalid1, rvalid2;
    logic                  ready, collision;
`ifdef MEM_PARITY_EN
    logic                  err1, err2;
`endif

    modport master (
        output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2,
`ifdef MEM_PARITY_EN
        input  err1, err2,
`endif
        input  rdata1, rdata2, rvalid1, rvalid2, ready, collision
    );

    modport slave (
        input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2,
`ifdef MEM_PARITY_EN
        output err1, err2,
`endif
        output rdata1, rdata2, rvalid1, rvalid2, ready, collision
    );
endinterface

// File: rtl/lane_banked_memory.sv
// Dual-port byte-lane memory with reset-time clear, 1/2-cycle read latency and collision flag.
// Optional per-lane even parity with err1/err2 when MEM_PARITY_EN is defined.
module lane_banked_memory_lane #(
    parameter int LANE_WIDTH  = 8,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_idx,
    input  logic                  re1,
    input  logic                  re2,
    input  logic                  we1,
    input  logic                  we2,
    input  logic [IDX_W-1:0]      idx1,
    input  logic [IDX_W-1:0]      idx2,
    input  logic [LANE_WIDTH-1:0] wd1,
    input  logic [LANE_WIDTH-1:0] wd2,
    output logic [LANE_WIDTH-1:0] rd1,
    output logic [LANE_WIDTH-1:0] rd2
`ifdef MEM_PARITY_EN
    ,
    output logic                  perr1,
    output logic                  perr2
`endif
);
`ifdef MEM_PARITY_EN
    localparam int CELL_W = LANE_WIDTH + 1;
    function automatic logic [CELL_W-1:0] enc(input logic [LANE_WIDTH-1:0] d);
        return {^d, d};
    endfunction
`else
    localparam int CELL_W = LANE_WIDTH;
    function automatic logic [CELL_W-1:0] enc(input logic [LANE_WIDTH-1:0] d);
        return d;
    endfunction
`endif

    logic [CELL_W-1:0] mem [DEPTH_WORDS];

    // Port 1 is written last so it wins a same-lane collision.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx] <= '0;
        end else begin
            if (we2) mem[idx2] <= enc(wd2);
            if (we1) mem[idx1] <= enc(wd1);
        end
    end

    // Sampled on the same edge as the write, so reads see pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
`ifdef MEM_PARITY_EN
            perr1 <= 1'b0;
            perr2 <= 1'b0;
`endif
        end else begin
            if (re1) rd1 <= mem[idx1][LANE_WIDTH-1:0];
            if (re2) rd2 <= mem[idx2][LANE_WIDTH-1:0];
`ifdef MEM_PARITY_EN
            if (re1) perr1 <= ^mem[idx1];
            if (re2) perr2 <= ^mem[idx2];
`endif
        end
    end
endmodule

module lane_banked_memory #(
    parameter int WORD_WIDTH     = 32,
    parameter int LANE_WIDTH     = 8,
    parameter int DEPTH_WORDS    = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                 clk,
    input logic                 rst,
    lane_banked_memory_if.slave bus
);
    localparam int LANES    = WORD_WIDTH / LANE_WIDTH;
    localparam int IDX_W    = $clog2(DEPTH_WORDS);
    localparam int ADDR_LSB = $clog2(LANES);

    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t state, state_nxt;

    logic [IDX_W-1:0] clr_cnt;
    logic             clr_en, ready;
    logic             acc1, acc2;
    logic [IDX_W-1:0] idx1, idx2;
    logic             unused_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_en) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && clr_cnt == IDX_W'(DEPTH_WORDS - 1)) state_nxt = S_RUN;
    end

    always_comb begin
        ready  = (state == S_RUN);
        clr_en = (state == S_CLEAR);
    end

    assign acc1        = bus.req1 & ready;
    assign acc2        = bus.req2 & ready;
    assign idx1        = bus.addr1[ADDR_LSB +: IDX_W];
    assign idx2        = bus.addr2[ADDR_LSB +: IDX_W];
    assign unused_addr = ^{bus.addr1, bus.addr2};
    assign bus.ready   = ready;

    logic [LANES-1:0][LANE_WIDTH-1:0] rd1, rd2;
`ifdef MEM_PARITY_EN
    logic [LANES-1:0] perr1, perr2;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_banked_memory_lane #(
            .LANE_WIDTH(LANE_WIDTH), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)
        ) u_lane (
            .clk(clk), .rst(rst), .clr_en(clr_en), .clr_idx(clr_cnt),
            .re1(acc1), .re2(acc2),
            .we1(acc1 & bus.we1[k]), .we2(acc2 & bus.we2[k]),
            .idx1(idx1), .idx2(idx2),
            .wd1(bus.wdata1[k*LANE_WIDTH +: LANE_WIDTH]),
            .wd2(bus.wdata2[k*LANE_WIDTH +: LANE_WIDTH]),
            .rd1(rd1[k]), .rd2(rd2[k])
`ifdef MEM_PARITY_EN
            , .perr1(perr1[k]), .perr2(perr2[k])
`endif
        );
    end

    // vld_pipe[s] = {port2, port1} request valid s cycles after acceptance.
    logic [READ_LATENCY:1][1:0] vld_pipe;
    logic                       col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            col_q    <= 1'b0;
        end else begin
            vld_pipe[1] <= {acc2, acc1};
            for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
            col_q <= acc1 & acc2 & (idx1 == idx2) & (|(bus.we1 & bus.we2));
        end
    end

    assign bus.collision = col_q;
    assign bus.rvalid1   = vld_pipe[READ_LATENCY][0];
    assign bus.rvalid2   = vld_pipe[READ_LATENCY][1];

    if (READ_LATENCY == 2) begin : g_lat2
        logic [WORD_WIDTH-1:0] rdata1_q, rdata2_q;
`ifdef MEM_PARITY_EN
        logic err1_q, err2_q;
`endif
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata1_q <= '0;
                rdata2_q <= '0;
`ifdef MEM_PARITY_EN
                err1_q <= 1'b0;
                err2_q <= 1'b0;
`endif
            end else begin
                if (vld_pipe[1][0]) rdata1_q <= rd1;
                if (vld_pipe[1][1]) rdata2_q <= rd2;
`ifdef MEM_PARITY_EN
                if (vld_pipe[1][0]) err1_q <= |perr1;
                if (vld_pipe[1][1]) err2_q <= |perr2;
`endif
            end
        end
        assign bus.rdata1 = rdata1_q;
        assign bus.rdata2 = rdata2_q;
`ifdef MEM_PARITY_EN
        assign bus.err1 = bus.rvalid1 & err1_q;
        assign bus.err2 = bus.rvalid2 & err2_q;
`endif
    end else begin : g_lat1
        assign bus.rdata1 = rd1;
        assign bus.rdata2 = rd2;
`ifdef MEM_PARITY_EN
        assign bus.err1 = bus.rvalid1 & (|perr1);
        assign bus.err2 = bus.rvalid2 & (|perr2);
`endif
    end
endmodule
